// File: rtl/circle_pkg.sv
// Shared state encoding, octant indices and decision-variable arithmetic
// for the midpoint circle rasteriser.
package circle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLOT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] OCT_0 = 3'd0;
  localparam logic [2:0] OCT_1 = 3'd1;
  localparam logic [2:0] OCT_2 = 3'd2;
  localparam logic [2:0] OCT_3 = 3'd3;
  localparam logic [2:0] OCT_4 = 3'd4;
  localparam logic [2:0] OCT_5 = 3'd5;
  localparam logic [2:0] OCT_6 = 3'd6;
  localparam logic [2:0] OCT_7 = 3'd7;

  localparam int CRIT_MAX_W = 16;
  typedef logic signed [CRIT_MAX_W-1:0] crit_t;

  // Midpoint decision update; x and y are the values before the step.
  function automatic crit_t crit_next(input crit_t crit, input crit_t x, input crit_t y);
    crit_t nxt;
    if (crit <= 16'sd0) begin
      nxt = crit + (y <<< 1) + 16'sd3;
    end else begin
      nxt = crit + ((y - x) <<< 1) + 16'sd5;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/circle_octant_map.sv
// Maps one (x, y) step into octant `oct` around the centre and reports whether
// the resulting pixel lies on screen and inside the x clip window.
module circle_octant_map
  import circle_pkg::*;
#(
  parameter int C_W      = 8,
  parameter int R_W      = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic [2:0]           oct_i,
  input  logic [C_W-1:0]       cx_i,
  input  logic [C_W-1:0]       cy_i,
  input  logic [R_W-1:0]       x_i,
  input  logic [R_W-1:0]       y_i,
  input  logic [C_W-1:0]       clip_xmin_i,
  input  logic [C_W-1:0]       clip_xmax_i,
  output logic signed [C_W+1:0] px_o,
  output logic signed [C_W+1:0] py_o,
  output logic                 in_bounds_o
);

  localparam int PW = C_W + 2;
  localparam logic signed [PW-1:0] SW_S = PW'(SCREEN_W);
  localparam logic signed [PW-1:0] SH_S = PW'(SCREEN_H);

  logic signed [PW-1:0] cx_s, cy_s, x_s, y_s, dx_s, dy_s;
  logic signed [PW-1:0] xmin_s, xmax_s, px_s, py_s;

  assign cx_s   = signed'({2'b00, cx_i});
  assign cy_s   = signed'({2'b00, cy_i});
  assign x_s    = signed'({{(PW-R_W){1'b0}}, x_i});
  assign y_s    = signed'({{(PW-R_W){1'b0}}, y_i});
  assign xmin_s = signed'({2'b00, clip_xmin_i});
  assign xmax_s = signed'({2'b00, clip_xmax_i});

  // Octant offset selection
  always_comb begin
    dx_s = '0;
    dy_s = '0;
    case (oct_i)
      OCT_0:   begin dx_s =  x_s; dy_s =  y_s; end
      OCT_1:   begin dx_s =  y_s; dy_s =  x_s; end
      OCT_2:   begin dx_s = -y_s; dy_s =  x_s; end
      OCT_3:   begin dx_s = -x_s; dy_s =  y_s; end
      OCT_4:   begin dx_s = -x_s; dy_s = -y_s; end
      OCT_5:   begin dx_s = -y_s; dy_s = -x_s; end
      OCT_6:   begin dx_s =  y_s; dy_s = -x_s; end
      OCT_7:   begin dx_s =  x_s; dy_s = -y_s; end
      default: begin dx_s = '0;   dy_s = '0;   end
    endcase
  end

  assign px_s = cx_s + dx_s;
  assign py_s = cy_s + dy_s;
  assign px_o = px_s;
  assign py_o = py_s;

  // Sign bit rules out negative coordinates before the upper-bound compares.
  assign in_bounds_o = !px_s[PW-1] && (px_s < SW_S) &&
                       !py_s[PW-1] && (py_s < SH_S) &&
                       (px_s >= xmin_s) && (px_s <= xmax_s);

endmodule

// File: rtl/circle_octant_engine.sv
// Midpoint circle rasteriser: walks one eighth of the circle and emits up to
// eight mirrored pixels per step, filtered by an octant mask and x clip window.
module circle_octant_engine
  import circle_pkg::*;
#(
  parameter int C_W      = 8,
  parameter int R_W      = 8,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [C_W-1:0]      centre_x,
  input  logic [C_W-1:0]      centre_y,
  input  logic [R_W-1:0]      radius,
  input  logic [7:0]          octant_mask,
  input  logic [C_W-1:0]      clip_xmin,
  input  logic [C_W-1:0]      clip_xmax,
  output logic                finished,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam int PW  = C_W + 2;
  localparam int XYW = R_W + 2;
  localparam int CW  = R_W + 3;
  localparam logic signed [XYW-1:0] ONE_XY = XYW'(1);
  localparam logic signed [CW-1:0]  ONE_C  = CW'(1);
  localparam logic signed [CW-1:0]  ZERO_C = '0;

  state_t                state_q;
  logic [C_W-1:0]        cx_q, cy_q, xmin_q, xmax_q;
  logic [7:0]            mask_q;
  logic [2:0]            oct_q;
  logic signed [XYW-1:0] x_q, y_q;
  logic signed [CW-1:0]  crit_q;
  logic                  finished_q, plot_q;
  logic [X_W-1:0]        vga_x_q;
  logic [Y_W-1:0]        vga_y_q;
  logic [COLOUR_W-1:0]   vga_colour_q;

  crit_t                 crit_wide_s;
  logic signed [CW-1:0]  crit_d;
  logic signed [XYW-1:0] x_d, y_d;
  logic                  done_s, in_bounds_s, hit_s;
  logic signed [PW-1:0]  px_s, py_s;
  logic                  unused_s;

  circle_octant_map #(
    .C_W      (C_W),
    .R_W      (R_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_map (
    .oct_i       (oct_q),
    .cx_i        (cx_q),
    .cy_i        (cy_q),
    .x_i         (x_q[R_W-1:0]),
    .y_i         (y_q[R_W-1:0]),
    .clip_xmin_i (xmin_q),
    .clip_xmax_i (xmax_q),
    .px_o        (px_s),
    .py_o        (py_s),
    .in_bounds_o (in_bounds_s)
  );

  assign hit_s = in_bounds_s & mask_q[oct_q];

  // Next (x, y, crit) after the current step; x and y kept signed so radius 0 terminates
  always_comb begin
    crit_wide_s = crit_next(crit_t'(crit_q), crit_t'(x_q), crit_t'(y_q));
    crit_d      = crit_wide_s[CW-1:0];
    y_d         = y_q + ONE_XY;
    if (crit_q <= ZERO_C) begin
      x_d = x_q;
    end else begin
      x_d = x_q - ONE_XY;
    end
    done_s = (y_d > x_d);
  end

  assign unused_s = ^{crit_wide_s[CRIT_MAX_W-1:CW], px_s[PW-1:X_W], py_s[PW-1:Y_W]};

  // Control FSM, step counters and registered pixel port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cx_q         <= '0;
      cy_q         <= '0;
      xmin_q       <= '0;
      xmax_q       <= '0;
      mask_q       <= '0;
      oct_q        <= OCT_0;
      x_q          <= '0;
      y_q          <= '0;
      crit_q       <= '0;
      finished_q   <= 1'b0;
      plot_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      plot_q <= 1'b0;
      case (state_q)
        IDLE: begin
          finished_q <= 1'b0;
          if (start) begin
            state_q <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          cx_q         <= centre_x;
          cy_q         <= centre_y;
          xmin_q       <= clip_xmin;
          xmax_q       <= clip_xmax;
          mask_q       <= octant_mask;
          vga_colour_q <= colour;
          x_q          <= signed'({2'b00, radius});
          y_q          <= '0;
          crit_q       <= ONE_C - signed'({3'b000, radius});
          oct_q        <= OCT_0;
          state_q      <= PLOT;
        end
        PLOT: begin
          plot_q <= hit_s;
          if (hit_s) begin
            vga_x_q <= px_s[X_W-1:0];
            vga_y_q <= py_s[Y_W-1:0];
          end
          oct_q <= oct_q + 3'd1;
          if (oct_q == OCT_7) begin
            x_q    <= x_d;
            y_q    <= y_d;
            crit_q <= crit_d;
            if (done_s) begin
              state_q    <= DONE;
              finished_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!start) begin
            state_q    <= IDLE;
            finished_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          finished_q <= 1'b0;
        end
      endcase
    end
  end

  assign finished   = finished_q;
  assign vga_plot   = plot_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;

endmodule

// File: tb/tb_circle_octant_engine.sv
// Directed, table-driven bench for circle_octant_engine: cycle counts, plot
// counts and pixel streams against hand-computed values and a reference walk.
module tb_circle_octant_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] colour = 3'd0;
  logic [7:0] centre_x = 8'd0, centre_y = 8'd0, radius = 8'd0, octant_mask = 8'd0;
  logic [7:0] clip_xmin = 8'd0, clip_xmax = 8'd0;
  logic       finished;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  always #5 clk = ~clk;

  circle_octant_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .colour(colour),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .octant_mask(octant_mask), .clip_xmin(clip_xmin), .clip_xmax(clip_xmax),
    .finished(finished), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  typedef struct {
    int cx; int cy; int r; int mask; int xmin; int xmax;
    int exp_cycles; int exp_plots;
  } vec_t;

  vec_t vecs[7];
  int   got_x[$], got_y[$], exp_x[$], exp_y[$];
  bit   capture = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (capture && vga_plot) begin
      got_x.push_back(int'(vga_x));
      got_y.push_back(int'(vga_y));
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic build_model(input vec_t v);
    int x, y, d, dx, dy, px, py;
    exp_x.delete();
    exp_y.delete();
    x = v.r; y = 0; d = 1 - v.r;
    do begin
      for (int o = 0; o < 8; o++) begin
        case (o)
          0:       begin dx =  x; dy =  y; end
          1:       begin dx =  y; dy =  x; end
          2:       begin dx = -y; dy =  x; end
          3:       begin dx = -x; dy =  y; end
          4:       begin dx = -x; dy = -y; end
          5:       begin dx = -y; dy = -x; end
          6:       begin dx =  y; dy = -x; end
          default: begin dx =  x; dy = -y; end
        endcase
        px = v.cx + dx;
        py = v.cy + dy;
        if (v.mask[o] && px >= 0 && px < 160 && py >= 0 && py < 120 &&
            px >= v.xmin && px <= v.xmax) begin
          exp_x.push_back(px);
          exp_y.push_back(py);
        end
      end
      if (d <= 0) begin
        d = d + 2 * y + 3; y = y + 1;
      end else begin
        d = d + 2 * (y - x) + 5; y = y + 1; x = x - 1;
      end
    end while (y <= x);
  endtask

  task automatic launch(input vec_t v, input int col);
    @(posedge clk); #1;
    centre_x    = 8'(v.cx);
    centre_y    = 8'(v.cy);
    radius      = 8'(v.r);
    octant_mask = 8'(v.mask);
    clip_xmin   = 8'(v.xmin);
    clip_xmax   = 8'(v.xmax);
    colour      = 3'(col);
    start       = 1'b1;
  endtask

  // Returns the number of edges until finished is seen (-1 on timeout).
  task automatic wait_finished(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk); #1;
      if (finished) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic run_draw(input vec_t v, input int col, output int cycles);
    got_x.delete();
    got_y.delete();
    launch(v, col);
    capture = 1'b1;
    wait_finished(cycles);
    @(negedge clk); #1;
    capture = 1'b0;
    start   = 1'b0;
  endtask

  task automatic check_draw(input string tag, input vec_t v, input int cycles);
    int mism;
    check({tag, "_cycles"}, cycles, v.exp_cycles);
    check({tag, "_plots"}, got_x.size(), v.exp_plots);
    build_model(v);
    mism = 0;
    for (int i = 0; i < exp_x.size(); i++) begin
      if (i >= got_x.size() || got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) mism++;
    end
    if (got_x.size() > exp_x.size()) mism += got_x.size() - exp_x.size();
    check({tag, "_stream_mismatches"}, mism, 0);
    @(posedge clk); #1;
    check({tag, "_finished_low"}, int'(finished), 0);
  endtask

  initial begin
    int cyc, bad;
    int hx[8];
    int hy[8];
    hx = '{90, 90, 90, 90, 89, 89, 88, 87};
    hy = '{60, 61, 62, 63, 64, 65, 66, 67};
    //            cx  cy  r  mask  xmin xmax cyc plots
    vecs[0] = '{80, 60, 10, 8'h01,   0, 255, 66,  8};
    vecs[1] = '{80, 60, 10, 8'hFF,   0, 255, 66, 64};
    vecs[2] = '{10, 10,  0, 8'hFF,   0, 255, 10,  8};
    vecs[3] = '{ 2,  2,  5, 8'hFF,   0, 255, 34, 14};
    vecs[4] = '{80, 60, 10, 8'hFF,  80, 159, 66, 34};
    vecs[5] = '{80, 60, 10, 8'hFF, 100,  50, 66,  0};
    vecs[6] = '{80, 60, 10, 8'h00,   0, 255, 66,  0};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_finished", int'(finished), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_x", int'(vga_x), 0);
    check("rst_y", int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_draw(vecs[i], i + 1, cyc);
      check($sformatf("v%0d_colour", i), int'(vga_colour), (i + 1) & 7);
      if (i == 0) begin
        for (int p = 0; p < 8; p++) begin
          check($sformatf("oct0_px%0d", p), (p < got_x.size()) ? got_x[p] : -1, hx[p]);
          check($sformatf("oct0_py%0d", p), (p < got_y.size()) ? got_y[p] : -1, hy[p]);
        end
      end
      if (i == 3) begin
        bad = 0;
        foreach (got_x[p]) if (got_x[p] >= 160 || got_y[p] >= 120) bad++;
        check("screen_clip_outside", bad, 0);
      end
      if (i == 4) begin
        bad = 0;
        foreach (got_x[p]) if (got_x[p] < 80) bad++;
        check("xwin_below_80", bad, 0);
      end
      check_draw($sformatf("v%0d", i), vecs[i], cyc);
    end

    // Reset in the middle of a full-circle draw
    launch(vecs[1], 2);
    repeat (22) @(posedge clk);
    #1;
    check("mid_pre_plot", int'(vga_plot), 1);
    check("mid_pre_x", int'(vga_x), 70);
    check("mid_pre_y", int'(vga_y), 62);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_plot", int'(vga_plot), 0);
    check("mid_rst_finished", int'(finished), 0);
    check("mid_rst_x", int'(vga_x), 0);
    check("mid_rst_colour", int'(vga_colour), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_draw(vecs[1], 2, cyc);
    check_draw("redraw", vecs[1], cyc);

    // Single-cycle start pulse: draw still completes, finished lasts one cycle
    launch(vecs[2], 4);
    @(posedge clk); #1;
    start = 1'b0;
    wait_finished(cyc);
    check("pulse_cycles", (cyc < 0) ? -1 : cyc + 1, 10);
    @(posedge clk); #1;
    check("pulse_finished_one_cycle", int'(finished), 0);

    // start held through DONE keeps finished high
    launch(vecs[2], 4);
    wait_finished(cyc);
    check("hold_cycles", cyc, 10);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (!finished || vga_plot) bad++;
    end
    check("hold_finished_50", bad, 0);
    start = 1'b0;
    @(posedge clk); #1;
    check("release_finished", int'(finished), 0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (finished || vga_plot) bad++;
    end
    check("idle_quiet", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/circle_octant_engine.md
Name: circle_octant_engine

Overview:
- Parametrised midpoint-circle rasteriser for the VGA drawing path.
- Plots any subset of the 8 octants, selected by `octant_mask`, with an additional x-window clip.
- One block serves full circles and every Reuleaux arc variant (left/right/top), replacing per-arc hard-coded drawers.
- Sits between the top-level shape sequencer (start/finished handshake) and the VGA adapter's pixel write port.

Parameters:
- C_W, 8, width of centre and clip coordinates.
- R_W, 8, radius width.
- X_W, 8, vga_x width.
- Y_W, 7, vga_y width.
- SCREEN_W, 160, pixels per row; plot only when px < SCREEN_W.
- SCREEN_H, 120, rows; plot only when py < SCREEN_H.
- COLOUR_W, 3, colour width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  level request; inputs sampled when leaving IDLE
- colour  in  COLOUR_W  pixel colour
- centre_x  in  C_W  circle centre x
- centre_y  in  C_W  circle centre y
- radius  in  R_W  radius
- octant_mask  in  8  bit k enables octant k
- clip_xmin  in  C_W  inclusive lower x bound
- clip_xmax  in  C_W  inclusive upper x bound
- finished  out  1  high in DONE
- vga_x  out  X_W  pixel x
- vga_y  out  Y_W  pixel y
- vga_colour  out  COLOUR_W  latched colour
- vga_plot  out  1  pixel write strobe

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. Reset takes effect on the next clk edge, from any state, including mid-draw.
- Reset values: state=IDLE, finished=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
- States:
  - IDLE: wait for start=1, then go to LOAD.
  - LOAD: one cycle. Latch all inputs; set x=radius, y=0, crit=1-radius (signed, R_W+3 bits); set oct=0. Go to PLOT.
  - PLOT: one cycle per octant index, 0..7. When oct=7, apply the update step: if the new y > new x, go to DONE; otherwise stay in PLOT with oct=0.
  - DONE: finished=1. Go to IDLE when start=0. If start is already 0, finished is high for exactly 1 cycle.
- Start deasserted during LOAD or PLOT is ignored; the draw completes.
- Octant map, as offsets from (cx, cy):
  - 0: (+x, +y)
  - 1: (+y, +x)
  - 2: (-y, +x)
  - 3: (-x, +y)
  - 4: (-x, -y)
  - 5: (-y, -x)
  - 6: (+y, -x)
  - 7: (+x, -y)
- Coordinate arithmetic: pixel coordinates are computed signed in C_W+2 bits, so there is no wraparound.
- Plot condition: vga_plot=1 in PLOT iff all of the following hold:
  - octant_mask[oct]=1;
  - 0 <= px < SCREEN_W;
  - 0 <= py < SCREEN_H;
  - clip_xmin <= px <= clip_xmax.
- Plot timing: vga_plot, vga_x and vga_y are registered outputs, valid together, 1 cycle after the PLOT cycle that produced them.
- Masked or clipped octants still consume their cycle. Timing is independent of mask and clip.
- When not plotting, vga_x and vga_y hold their last value.
- Update step, applied after oct=7 (uses the old y):
  - If crit <= 0 (signed, zero included): crit += 2y+3; y += 1.
  - Otherwise: crit += 2(y-x)+5; y += 1; x -= 1.
- Iteration and latency: one iteration per (x, y) with y <= x. Latency from start sampled to finished = 1 (LOAD) + 8N (PLOT) + 1 cycles, where N is the iteration count.
- radius=0: N=1, giving 8 plot cycles all at (cx, cy).
- clip_xmin > clip_xmax: nothing plots, but timing is unchanged.
- Duplicate pixels at octant seams (y=0, x=y) are plotted as-is; no suppression.

Decomposition:
- Package circle_pkg contains:
  - state enum {IDLE, LOAD, PLOT, DONE};
  - octant index constants OCT_0..OCT_7;
  - function crit_next().
- Sub-module circle_octant_map, purely combinational:
  - inputs: oct, cx, cy, x, y, clip bounds;
  - outputs: px, py (signed) and in_bounds;
  - parametrised with C_W, SCREEN_W, SCREEN_H.
- The main module holds the FSM, the counters and the output registers.

Test Plan:
- Reset mid-draw: centre (80,60), r=10, mask 0xFF; rst_n=0 at PLOT cycle 20. Next edge: vga_plot=0, finished=0; the block redraws cleanly on a new start.
- Single octant: centre (80,60), r=10, mask 0x01. Exactly 8 plots, in order: (90,60), (90,61), (90,62), (90,63), (89,64), (89,65), (88,66), (87,67). finished rises 66 cycles after start is sampled.
- Screen clip: centre (2,2), r=5, mask 0xFF. No plot has px or py outside 0..159 / 0..119. Total cycle count equals the unclipped r=5 case (N=4, 34 cycles).
- x-window clip: centre (80,60), r=10, mask 0xFF, clip [80,159]. Every plotted px >= 80. Octants 2..5 contribute only pixels with px=80.
- radius=0: centre (10,10), mask 0xFF. 8 plots, all at (10,10). finished high 10 cycles after start is sampled.
- Handshake: start held high through DONE keeps finished=1 for 50 cycles. Dropping start returns the block to IDLE next cycle with finished=0. Start held low gives no activity.
